dspdecimate: RTL and testbench

Integrate-and-dump decimator that sits directly downstream of the filter/bypass switch and consumes its clock-enabled sample stream. It averages each block of 2^lg consecutive valid input samples into one rounded output sample, so the sample rate drops by a power of two selectable at run time. Output uses the same single-cycle clock-enable convention as its input, so the block can feed any later stage in the chain.

---
 rtl/dspdecimate.sv | 70 +++++++
 tb/tb_dspdecimate.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dspdecimate.sv
// Integrate-and-dump decimator: averages each block of 2^lg valid samples into
// one rounded output, with a single-cycle clock-enable on the output.
module dspdecimate #(
    parameter int IW          = 32,
    parameter int LGMAX       = 4,
    parameter int LGDEC_RESET = 0
) (
    input  logic                       i_clk,
    input  logic                       i_areset_n,
    input  logic                       i_ce,
    input  logic [IW-1:0]              i_sample,
    input  logic                       i_wr,
    input  logic [$clog2(LGMAX+1)-1:0] i_lgdec,
    output logic                       o_ce,
    output logic [IW-1:0]              o_sample
);
    localparam int AW  = IW + LGMAX;
    localparam int LGW = $clog2(LGMAX + 1);

    logic [LGW-1:0]        lg;
    logic [LGW-1:0]        lg_req;
    logic [LGMAX-1:0]      cnt;
    logic [LGMAX-1:0]      last_cnt;
    logic [LGMAX:0]        blk_len;
    logic                  dump;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  half;
    logic signed [AW-1:0]  rounded;

    // Sum plus half fits AW: 2^LGMAX * max(IW) + 2^(LGMAX-1) stays below 2^(AW-1).
    always_comb begin
        blk_len  = (LGMAX + 1)'(1) << lg;
        last_cnt = LGMAX'(blk_len - (LGMAX + 1)'(1));
        dump     = i_ce && (cnt == last_cnt);
        sum      = acc + AW'($signed(i_sample));
        half     = (lg == '0) ? '0 : (AW'(1) << (lg - LGW'(1)));
        rounded  = sum + half;
        lg_req   = (i_lgdec > LGW'(LGMAX)) ? LGW'(LGMAX) : i_lgdec;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            lg       <= LGW'(LGDEC_RESET);
            cnt      <= '0;
            acc      <= '0;
            o_ce     <= 1'b0;
            o_sample <= '0;
        end else begin
            o_ce <= 1'b0;
            // A ratio write restarts the block and swallows any same-cycle sample.
            if (i_wr) begin
                lg  <= lg_req;
                acc <= '0;
                cnt <= '0;
            end else if (i_ce) begin
                if (dump) begin
                    o_sample <= IW'(rounded >>> lg);
                    o_ce     <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + LGMAX'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dspdecimate.sv
// Bench for dspdecimate: block-average reference model feeding a scoreboard,
// directed scenarios followed by randomized samples and ratio writes.
module tb_dspdecimate;
  localparam int IW          = 16;
  localparam int LGMAX       = 4;
  localparam int LGW         = 3;
  localparam int LGDEC_RESET = 0;

  logic           clk = 1'b0;
  logic           areset_n = 1'b0;
  logic           i_ce = 1'b0;
  logic [IW-1:0]  i_sample = '0;
  logic           i_wr = 1'b0;
  logic [LGW-1:0] i_lgdec = '0;
  logic           o_ce;
  logic [IW-1:0]  o_sample;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [IW-1:0] exp_q[$];
  int            exp_t_q[$];
  int            blk[$];
  int            lg_m = LGDEC_RESET;
  logic [IW-1:0] last_out = '0;

  dspdecimate #(.IW(IW), .LGMAX(LGMAX), .LGDEC_RESET(LGDEC_RESET)) dut (
    .i_clk(clk),
    .i_areset_n(areset_n),
    .i_ce(i_ce),
    .i_sample(i_sample),
    .i_wr(i_wr),
    .i_lgdec(i_lgdec),
    .o_ce(o_ce),
    .o_sample(o_sample)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mean of the block, plus half an LSB, floored.
  function automatic logic [IW-1:0] avg(input int s[$], input int lg);
    longint sum;
    longint d;
    longint h;
    longint q;
    sum = 0;
    foreach (s[i]) sum += s[i];
    d = longint'(1) << lg;
    h = sum + d / 2;
    q = h / d;
    if ((h % d) != 0 && h < 0) q = q - 1;
    return q[IW-1:0];
  endfunction

  // One cycle of stimulus; the model is updated with the same inputs.
  task automatic drive(input logic ce, input logic [IW-1:0] s, input logic wr,
                       input logic [LGW-1:0] lgd);
    @(negedge clk);
    i_ce = ce;
    i_sample = s;
    i_wr = wr;
    i_lgdec = lgd;
    if (wr) begin
      lg_m = (int'(lgd) > LGMAX) ? LGMAX : int'(lgd);
      blk.delete();
    end else if (ce) begin
      blk.push_back(int'($signed(s)));
      if (blk.size() == (1 << lg_m)) begin
        exp_q.push_back(avg(blk, lg_m));
        exp_t_q.push_back(cyc + 1);
        blk.delete();
      end
    end
  endtask

  task automatic sample(input logic [IW-1:0] s);
    drive(1'b1, s, 1'b0, '0);
  endtask

  task automatic set_lg(input logic [LGW-1:0] l);
    drive(1'b0, '0, 1'b1, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [IW-1:0] e;
    int t;
    forever begin
      @(negedge clk);
      if (!areset_n) begin
        last_out = '0;
      end else if (o_ce) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_o_ce: got o_sample %0h expected no output (cycle %0d)",
                   o_sample, cyc);
        end else begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          chk("o_sample", o_sample, e);
          chk("o_ce_latency", cyc, t);
        end
        last_out = o_sample;
      end else begin
        chk("o_sample_hold", o_sample, last_out);
      end
    end
  end

  initial begin
    // reset state
    #23;
    chk("reset_o_ce", o_ce, 0);
    chk("reset_o_sample", o_sample, 0);
    @(negedge clk);
    areset_n = 1'b1;
    idle(2);
    chk("pre_ce_o_ce", o_ce, 0);
    chk("pre_ce_o_sample", o_sample, 0);

    // pass-through at lg=0
    sample(16'h1234);
    idle(2);
    chk("pass_through", o_sample, 16'h1234);

    // block of four with gaps
    set_lg(3'd2);
    sample(16'd1); idle(2);
    sample(16'd2); idle(1);
    sample(16'd3); idle(3);
    sample(16'd4); idle(2);
    chk("avg4_gaps", o_sample, 16'd3);

    // negative rounding
    set_lg(3'd1);
    sample(16'hFFFD); sample(16'hFFFE); idle(2);
    chk("neg_round", o_sample, 16'hFFFE);
    sample(16'hFFFF); sample(16'h0000); idle(2);
    chk("half_up", o_sample, 16'h0000);

    // extremes at lg=4
    set_lg(3'd4);
    for (int i = 0; i < 16; i++) sample(16'h7FFF);
    idle(2);
    chk("max16", o_sample, 16'h7FFF);
    for (int i = 0; i < 16; i++) sample(16'h8000);
    idle(2);
    chk("min16", o_sample, 16'h8000);
    for (int i = 0; i < 16; i++) sample((i % 2 == 0) ? 16'h7FFF : 16'h8000);
    idle(2);
    chk("alt16", o_sample, 16'h0000);

    // ratio change mid-block, same-cycle sample dropped
    set_lg(3'd2);
    sample(16'd50); sample(16'd60);
    drive(1'b1, 16'd99, 1'b1, 3'd1);
    idle(2);
    sample(16'd6); sample(16'd8); idle(2);
    chk("after_wr", o_sample, 16'd7);

    // clamped ratio write
    set_lg(3'd7);
    for (int i = 0; i < 16; i++) sample(16'(i * 10));
    idle(2);
    chk("clamp_lg4", o_sample, 16'd75);

    // async reset mid-block
    set_lg(3'd3);
    sample(16'd11); sample(16'd22); sample(16'd33);
    @(negedge clk);
    i_ce = 1'b0;
    i_wr = 1'b0;
    #2 areset_n = 1'b0;
    blk.delete();
    lg_m = LGDEC_RESET;
    #1;
    chk("async_o_ce", o_ce, 0);
    chk("async_o_sample", o_sample, 0);
    @(negedge clk);
    #2 areset_n = 1'b1;
    idle(1);
    sample(16'h0055);
    idle(2);
    chk("post_reset_pass", o_sample, 16'h0055);

    // randomized samples and ratio writes
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) set_lg(LGW'($urandom_range(0, 7)));
      else if (r < 65) sample(IW'($urandom));
      else idle(1);
    end
    idle(5);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
